window_generator_3x3: RTL and testbench

- Streaming producer of the 3x3 pixel window (X0..X8) consumed by the salt/pepper noise detector stage and the switching median stage.
- Accepts one raster-order pixel per valid cycle, buffers two previous image lines, and emits a registered 3x3 neighbourhood whenever a full window exists in the current frame.
- No backpressure; the downstream stages are combinational or fully pipelined.

---
 rtl/window_generator_3x3.sv | 140 ++++++++++++++
 tb/tb_window_generator_3x3.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/window_generator_3x3.sv
// window_generator_3x3: streams raster pixels through two line buffers
// and a 3x3 shift window for the noise detector and median stages.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   pix_in       raster-order input pixel
//   pix_valid    pix_in is accepted this cycle
//   sof          pixel is (0,0); only sampled with pix_valid
//   X0..X8       window, rows top to bottom, columns left to right
//   win_valid    X0..X8 hold a complete window this cycle
//   win_row/col  position of the centre pixel X4
module window_generator_3x3 #(
  parameter int PIX_W      = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PIX_W-1:0]              pix_in,
  input  logic                          pix_valid,
  input  logic                          sof,
  output logic [PIX_W-1:0]              X0,
  output logic [PIX_W-1:0]              X1,
  output logic [PIX_W-1:0]              X2,
  output logic [PIX_W-1:0]              X3,
  output logic [PIX_W-1:0]              X4,
  output logic [PIX_W-1:0]              X5,
  output logic [PIX_W-1:0]              X6,
  output logic [PIX_W-1:0]              X7,
  output logic [PIX_W-1:0]              X8,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    c;
  logic [RW-1:0]    r;

  logic [PIX_W-1:0] lb1_q [IMG_WIDTH];
  logic [PIX_W-1:0] lb2_q [IMG_WIDTH];
  logic [PIX_W-1:0] t, m;

  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic             vld_q, vld_d;
  logic [RW-1:0]    wrow_q, wrow_d;
  logic [CW-1:0]    wcol_q, wcol_d;

  // sof overrides the counters so the pixel is (0,0) immediately
  assign c = sof ? '0 : col_q;
  assign r = sof ? '0 : row_q;

  // old contents, read before this cycle's write lands
  assign t = lb2_q[c];
  assign m = lb1_q[c];

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    win_d  = win_q;
    vld_d  = 1'b0;
    wrow_d = wrow_q;
    wcol_d = wcol_q;
    if (pix_valid) begin
      if (c == COL_MAX) begin
        col_d = '0;
        row_d = (r == ROW_MAX) ? '0 : r + 1'b1;
      end else begin
        col_d = c + 1'b1;
        row_d = r;
      end
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = t;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = m;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      // c>=2 keeps windows from straddling a line wrap;
      // r>=2 keeps stale line-buffer rows out after sof/reset
      if (r >= ROW_TWO && c >= COL_TWO) begin
        vld_d  = 1'b1;
        wrow_d = r - 1'b1;
        wcol_d = c - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      win_q  <= '{default: '0};
      vld_q  <= 1'b0;
      wrow_q <= '0;
      wcol_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win_q  <= win_d;
      vld_q  <= vld_d;
      wrow_q <= wrow_d;
      wcol_q <= wcol_d;
    end
  end

  // line-buffer RAM carries no reset
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2_q[c] <= m;
      lb1_q[c] <= pix_in;
    end
  end

  assign X0        = win_q[0];
  assign X1        = win_q[1];
  assign X2        = win_q[2];
  assign X3        = win_q[3];
  assign X4        = win_q[4];
  assign X5        = win_q[5];
  assign X6        = win_q[6];
  assign X7        = win_q[7];
  assign X8        = win_q[8];
  assign win_valid = vld_q;
  assign win_row   = wrow_q;
  assign win_col   = wcol_q;

endmodule

// File: tb/tb_window_generator_3x3.sv
// tb_window_generator_3x3: scoreboard bench for the 3x3 window
// generator on a 4x4 image.
module tb_window_generator_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [7:0] X0, X1, X2, X3, X4, X5, X6, X7, X8;
  logic       win_valid;
  logic [1:0] win_row;
  logic [1:0] win_col;

  window_generator_3x3 #(
    .PIX_W     (8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .sof      (sof),
    .X0       (X0),
    .X1       (X1),
    .X2       (X2),
    .X3       (X3),
    .X4       (X4),
    .X5       (X5),
    .X6       (X6),
    .X7       (X7),
    .X8       (X8),
    .win_valid(win_valid),
    .win_row  (win_row),
    .win_col  (win_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] x;
    int          row;
    int          col;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  img [H][W];
  int          mr = 0;
  int          mc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          nwin = 0;
  bit          mon_en = 1'b0;
  bit          rst_hit = 1'b0;
  logic        prev_pv = 1'b0;
  logic [79:0] prev_st = '0;

  task automatic check(input string tag,
                       input logic [79:0] got,
                       input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] cur_x();
    return {X0, X1, X2, X3, X4, X5, X6, X7, X8};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst_hit) begin
      if (!prev_pv) begin
        check("gap_valid", 80'(win_valid), 80'(0));
        check("gap_hold", {cur_x(), win_row, win_col}, prev_st);
      end else if (win_valid) begin
        if (q.size() == 0) begin
          check("extra_win", 80'(win_valid), 80'(0));
        end else begin
          e = q.pop_front();
          if (nwin == 0)
            check("first_win", 80'(cur_x()),
                  80'(72'h000102101112202122));
          check("win_x", 80'(cur_x()), 80'(e.x));
          check("win_row", 80'(win_row), 80'(e.row));
          check("win_col", 80'(win_col), 80'(e.col));
          nwin++;
        end
      end
    end
    rst_hit = 1'b0;
    prev_pv = pix_valid;
    prev_st = {cur_x(), win_row, win_col};
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      sof       = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] v, input logic s,
                      input int gap);
    exp_t e;
    idle(gap);
    @(posedge clk);
    #1;
    pix_in    = v;
    pix_valid = 1'b1;
    sof       = s;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = v;
    if (mr >= 2 && mc >= 2) begin
      e.x = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
             img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
             img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
      e.row = mr - 1;
      e.col = mc - 1;
      q.push_back(e);
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  // mode 0: 16r+c, 1: with gaps, 2: (2,3)=FF, 3: 80h+16r+c,
  // 4: random values
  task automatic frame(input int mode, input bit use_sof);
    logic [7:0] v;
    int         gap;
    int         base;
    base = nwin;
    for (int i = 0; i < W * H; i++) begin
      v   = 8'(16 * (i / W) + (i % W));
      gap = 0;
      case (mode)
        1: gap = ($urandom_range(0, 2) == 0) ?
                 int'($urandom_range(1, 3)) : 0;
        2: if (i == 2 * W + 3) v = 8'hFF;
        3: v = v + 8'h80;
        4: v = 8'($urandom);
        default: ;
      endcase
      send(v, use_sof && i == 0, gap);
    end
    idle(3);
    check("nwin_frame", 80'(nwin - base), 80'(4));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_x", 80'(cur_x()), 80'(0));
    check("rst_vld_pos", 80'({win_valid, win_row, win_col}), 80'(0));
    rst     = 1'b0;
    rst_hit = 1'b1;
    mr      = 0;
    mc      = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    pix_in    = '0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    #1;
    check("por_x", 80'(cur_x()), 80'(0));
    check("por_vld_pos", 80'({win_valid, win_row, win_col}), 80'(0));
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    frame(0, 1'b1);
    frame(1, 1'b1);
    frame(2, 1'b1);

    for (int i = 0; i < W + 2; i++)
      send(8'(8'h60 + i), i == 0, 0);
    frame(3, 1'b1);

    for (int i = 0; i < 2 * W + 2; i++)
      send(8'(8'h40 + i), i == 0, 0);
    pulse_reset();
    frame(4, 1'b0);

    idle(3);
    check("drain", 80'(q.size()), 80'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
